seq_datapath: RTL

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_dp_pkg.sv | 28 ++
 rtl/dp_alu.sv | 48 ++++
 rtl/seq_datapath.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq_dp_pkg.sv
// Shared definitions for the sequential single-bus datapath: opcodes, FSM
// states and the reserved-opcode test.
package seq_dp_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_LDI = 4'd7,
    OP_MOV = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_e;

  function automatic logic op_reserved(input logic [3:0] op);
    return (op > 4'd8);
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for seq_datapath: combines latched Y with the bus value.
module dp_alu
  import seq_dp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] y,
  input  logic [W-1:0] bus,
  input  logic [3:0]   op,
  output logic [W-1:0] result,
  output logic         carry
);

  localparam int SHW = $clog2(W);

  logic [W:0]     sum;
  logic [SHW-1:0] amt;

  assign amt = bus[SHW-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    sum    = '0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, y} + {1'b0, bus};
        result = sum[W-1:0];
        carry  = sum[W];
      end
      // Carry out of the two's-complement add is the "no borrow" indication.
      OP_SUB: begin
        sum    = {1'b0, y} + {1'b0, ~bus} + {{W{1'b0}}, 1'b1};
        result = sum[W-1:0];
        carry  = sum[W];
      end
      OP_AND:  result = y & bus;
      OP_OR:   result = y | bus;
      OP_XOR:  result = y ^ bus;
      OP_SHL:  result = y << amt;
      OP_SHR:  result = y >> amt;
      OP_LDI:  result = bus;
      OP_MOV:  result = y;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/seq_datapath.sv
// Three-phase single-bus datapath: T1 reads rs1 into Y, T2 runs the ALU into Z,
// T3 writes Z back to rd and pulses done.
module seq_datapath
  import seq_dp_pkg::*;
#(
  parameter  int W    = 32,
  parameter  int NREG = 16,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_rs1,
  input  logic [RW-1:0] cmd_rs2,
  input  logic [W-1:0]  cmd_imm,
  output logic          done,
  output logic          cmd_err,
  output logic          flag_zero,
  output logic          flag_carry,
  output logic [W-1:0]  bus_out,
  input  logic [RW-1:0] dbg_sel,
  output logic [W-1:0]  dbg_data
);

  state_e        state;
  logic [W-1:0]  regs [NREG];
  logic [3:0]    op_q;
  logic [RW-1:0] rd_q, rs1_q, rs2_q;
  logic [W-1:0]  imm_q, y_q, z_q;
  logic [W-1:0]  bus;
  logic [W-1:0]  alu_res;
  logic          alu_carry;

  always_comb begin
    bus = '0;
    case (state)
      T1:      bus = regs[rs1_q];
      T2:      bus = (op_q == OP_LDI) ? imm_q : regs[rs2_q];
      T3:      bus = z_q;
      default: bus = '0;
    endcase
  end

  assign bus_out   = bus;
  assign cmd_ready = (state == IDLE);
  assign dbg_data  = regs[dbg_sel];

  dp_alu #(.W(W)) u_alu (
    .y      (y_q),
    .bus    (bus),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      y_q        <= '0;
      z_q        <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            imm_q <= cmd_imm;
            state <= T1;
          end
        end
        T1: begin
          y_q   <= bus;
          state <= T2;
        end
        T2: begin
          if (!op_reserved(op_q)) begin
            z_q        <= alu_res;
            flag_zero  <= (alu_res == '0);
            flag_carry <= alu_carry;
          end
          state <= T3;
        end
        T3: begin
          if (!op_reserved(op_q)) regs[rd_q] <= bus;
          done    <= 1'b1;
          cmd_err <= op_reserved(op_q);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
